// File: rtl/axis_rr_arbiter.sv
// N-channel AXI-Stream packet arbiter and mux: picks one requester (fixed priority or
// round-robin), then locks the grant until that packet's tlast beat has transferred.
module axis_rr_arbiter #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 8,
    parameter int RR_MODE = 1,
    parameter int ID_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH*DATA_W-1:0]   s_tdata,
    input  logic [N_CH-1:0]          s_tvalid,
    input  logic [N_CH-1:0]          s_tlast,
    output logic [N_CH-1:0]          s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    output logic [ID_W-1:0]          m_tid,
    input  logic                     m_tready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   grant, grant_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [ID_W-1:0]   winner, win_hi, win_lo;
    logic              found_hi;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              active;

    // Round-robin scan split in two halves: requesters at or above ptr take precedence
    // over those below it; descending loop leaves the lowest index of each half.
    // With fixed priority ptr never leaves 0, so the upper half covers every channel.
    always_comb begin
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (s_tvalid[i]) begin
                if (i >= int'(ptr)) begin
                    win_hi   = ID_W'(i);
                    found_hi = 1'b1;
                end else begin
                    win_lo = ID_W'(i);
                end
            end
        end
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == ID_W'(i)) begin
                sel_data  = s_tdata[i*DATA_W +: DATA_W];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    // Outputs are masked while rst is high so no beat can transfer in the reset cycle.
    always_comb begin
        active   = (state == BUSY) && !rst;
        m_tvalid = active && sel_valid;
        m_tlast  = active && sel_last;
        m_tdata  = active ? sel_data : '0;
        m_tid    = active ? grant : '0;
        s_tready = '0;
        for (int i = 0; i < N_CH; i++) begin
            s_tready[i] = active && (grant == ID_W'(i)) && m_tready;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|s_tvalid) begin
                    grant_nxt = winner;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (m_tvalid && m_tready && m_tlast) begin
                    state_nxt = IDLE;
                    if (RR_MODE != 0) begin
                        ptr_nxt = (int'(grant) == N_CH - 1) ? '0 : grant + ID_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            ptr   <= ptr_nxt;
        end
    end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Parametrised N-channel AXI-Stream packet arbiter and mux; successor to the combinational priority encoder.
- Selects one requesting slave channel, either by fixed priority (lowest index wins) or by round-robin.
- Locks the grant until the packet's tlast beat transfers, then forwards that packet to a single master port.
- Sits in front of the SERDES framer to merge several lane/packet sources into one stream.

Parameters:
- N_CH, 4, number of slave channels (>=1; non-power-of-2 legal).
- DATA_W, 8, tdata width per channel.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- ID_W, (N_CH>1 ? $clog2(N_CH) : 1), width of m_tid (derived; not to be overridden).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- s_tdata  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- s_tvalid  in  N_CH  per-channel valid.
- s_tlast  in  N_CH  per-channel end-of-packet.
- s_tready  out  N_CH  per-channel ready; at most one bit set (one-hot or zero).
- m_tdata  out  DATA_W  selected channel data.
- m_tvalid  out  1  master valid.
- m_tlast  out  1  master end-of-packet.
- m_tid  out  ID_W  index of granted channel.
- m_tready  in  1  downstream ready.

Behaviour:
- Reset: one clock, synchronous, active-high. Reset values: state=IDLE, grant=0, ptr=0. Outputs: s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, m_tid=0.
- Reset asserted mid-packet aborts the packet: the next cycle is IDLE with ptr=0. No beat transfers during the cycle rst is high.

States:
- IDLE:
  - All s_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0, m_tid=0.
  - If any s_tvalid is set, register the winner into grant and move to BUSY. Otherwise stay in IDLE.
- BUSY:
  - Combinational pass-through of channel `grant`: m_tdata/m_tlast/m_tvalid = s_*[grant], s_tready[grant] = m_tready, all other s_tready=0, m_tid=grant.
  - A beat transfers when m_tvalid && m_tready.
  - If a beat transfers with m_tlast=1: go to IDLE, and in RR_MODE=1 set ptr = (grant+1) mod N_CH.
  - Otherwise stay in BUSY. This holds even if s_tvalid[grant] deasserts mid-packet: the grant stays locked and other channels are never granted mid-packet.

Arbitration (evaluated in IDLE only):
- RR_MODE=0: lowest set index of s_tvalid wins. ptr stays 0.
- RR_MODE=1: first set index scanning ptr, ptr+1, ..., N_CH-1, 0, ..., ptr-1, with wrap-around.
- Requests seen in IDLE are sampled only in that cycle. A channel dropping valid before the grant registers still owns the BUSY state until it sends tlast. Sources are AXIS-compliant and never drop valid, so this case does not occur legally.

Timing:
- Arbitration latency: first beat of a packet is presentable 1 cycle after the IDLE cycle in which its valid was seen.
- Throughput: 1 beat/cycle within a packet. Exactly one IDLE bubble cycle between consecutive packets.
- Single-beat packets (tlast on first beat) occupy 2 cycles minimum: IDLE + BUSY.
- m_tready low in BUSY stalls the packet. Output holds the source values; the source holds them per AXIS rules.
- N_CH=1: m_tid is always 0, ptr is always 0, behaviour is otherwise identical.

Test Plan:
1. RR_MODE=0, N_CH=4: s_tvalid=4'b1010, each channel sending 1-beat packets continuously -> ch1 granted every packet and ch3 starved; m_tid=1; one IDLE bubble between packets.
2. RR_MODE=1, N_CH=4: all valid, 2-beat packets -> m_tid sequence 0,1,2,3,0,…; each packet 3 cycles (IDLE+2 beats); s_tready one-hot on the granted channel only.
3. RR_MODE=1, N_CH=3 (non-power-of-2): ptr=2 after ch1 packet, requests 3'b011 -> ch0 wins (wrap past index 2, which has no request); then ptr=1.
4. Packet lock: ch0 sends 4-beat packet (0xA0..0xA3), ch2 raises valid at beat 1, ch0 drops valid for 2 cycles mid-packet -> m_tid stays 0, s_tready[2]=0 throughout, ch2 granted only after the 0xA3/tlast handshake plus one IDLE cycle.
5. Backpressure: m_tready toggled 1,0,0,1 during a 3-beat packet -> m_tdata/m_tvalid held while m_tready=0, exactly 3 transfers in order, s_tready[grant] mirrors m_tready.
6. rst pulsed high for 1 cycle during beat 2 of a 4-beat packet -> next cycle IDLE, all outputs 0, ptr=0; a new request on ch3 is granted with m_tid=3 one cycle later.
